// File: rtl/wb_daq_csr_pkg.sv
// rtl/wb_daq_csr_pkg.sv - register map, layout constants and FSM encoding for the DAQ CSR bank
package wb_daq_csr_pkg;

  localparam int          MAX_CH          = 8;
  localparam logic [15:0] VERSION_DEFAULT = 16'h0002;

  // Word offsets inside the global block (0x00..0x0C)
  localparam logic [1:0] G_CONTROL    = 2'd0;
  localparam logic [1:0] G_IRQ_STATUS = 2'd1;
  localparam logic [1:0] G_IRQ_ENABLE = 2'd2;
  localparam logic [1:0] G_CONFIG     = 2'd3;

  // Word offsets inside each 16-byte channel block
  localparam logic [1:0] C_ADDRESS = 2'd0;
  localparam logic [1:0] C_CONTROL = 2'd1;
  localparam logic [1:0] C_STATUS  = 2'd2;
  localparam logic [1:0] C_RSVD    = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_daq_csr_channel.sv
// rtl/wb_daq_csr_channel.sv - one channel's ADDRESS/CONTROL registers and read mux
module wb_daq_csr_channel
  import wb_daq_csr_pkg::*;
(
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        wr_en,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  input  logic [3:0]  sel,
  input  logic [31:0] ch_status,
  output logic [31:0] ch_address,
  output logic [31:0] ch_control,
  output logic [31:0] rd_data
);

  logic [31:0] mask;

  assign mask = lane_mask(sel);

  // STATUS writes are accepted by the top but simply never land here
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      ch_address <= '0;
      ch_control <= '0;
    end else if (wr_en) begin
      if (reg_sel == C_ADDRESS) ch_address <= (ch_address & ~mask) | (wdata & mask);
      if (reg_sel == C_CONTROL) ch_control <= (ch_control & ~mask) | (wdata & mask);
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      C_ADDRESS: rd_data = ch_address;
      C_CONTROL: rd_data = ch_control;
      C_STATUS:  rd_data = ch_status;
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: rtl/wb_daq_csr_bank.sv
// rtl/wb_daq_csr_bank.sv - Wishbone DAQ register slave: FSM, decode, global/IRQ registers, read mux
module wb_daq_csr_bank
  import wb_daq_csr_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          AW      = 8,
  parameter logic [15:0] VERSION = VERSION_DEFAULT
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic [AW-1:0]       wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [2:0]          wb_cti_i,
  input  logic [1:0]          wb_bte_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [31:0]         daq_control_reg,
  output logic [NUM_CH*32-1:0] daq_ch_address,
  output logic [NUM_CH*32-1:0] daq_ch_control,
  input  logic [NUM_CH*32-1:0] daq_ch_status,
  input  logic [NUM_CH-1:0]   daq_ch_event,
  output logic                interrupt
);

  localparam int CW = AW - 4;

  state_t            state;
  logic              access, wr, unmapped, is_global;
  logic [CW-1:0]     blk, ch_idx;
  logic [1:0]        off;
  logic [NUM_CH-1:0] ch_hit, ch_wr, irq_st, irq_en, irq_clr;
  logic [31:0]       ch_rd [NUM_CH];
  logic [31:0]       rd_mux, mask, config_word;
  logic              unused_ok;

  assign blk         = wb_adr_i[AW-1:4];
  assign off         = wb_adr_i[3:2];
  assign is_global   = (blk == '0);
  assign ch_idx      = blk - CW'(1);
  assign access      = (state == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign mask        = lane_mask(wb_sel_i);
  assign config_word = {VERSION, 8'h00, 8'(NUM_CH)};
  assign wb_rty_o    = 1'b0;
  assign unused_ok   = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NUM_CH; i++) ch_hit[i] = !is_global && (ch_idx == CW'(i));
    unmapped = !is_global && ((ch_hit == '0) || (off == C_RSVD));
  end

  assign wr      = access && wb_we_i && !unmapped;
  assign ch_wr   = wr ? ch_hit : '0;
  assign irq_clr = (wr && is_global && off == G_IRQ_STATUS) ?
                   (wb_dat_i[NUM_CH-1:0] & mask[NUM_CH-1:0]) : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wb_daq_csr_channel u_ch (
      .wb_clk     (wb_clk),
      .wb_rst     (wb_rst),
      .wr_en      (ch_wr[g]),
      .reg_sel    (off),
      .wdata      (wb_dat_i),
      .sel        (wb_sel_i),
      .ch_status  (daq_ch_status[32*g +: 32]),
      .ch_address (daq_ch_address[32*g +: 32]),
      .ch_control (daq_ch_control[32*g +: 32]),
      .rd_data    (ch_rd[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (is_global) begin
      case (off)
        G_CONTROL:    rd_mux = daq_control_reg;
        G_IRQ_STATUS: rd_mux = 32'(irq_st);
        G_IRQ_ENABLE: rd_mux = 32'(irq_en);
        default:      rd_mux = config_word;
      endcase
    end else begin
      for (int i = 0; i < NUM_CH; i++) if (ch_hit[i]) rd_mux = ch_rd[i];
    end
  end

  // Event set is OR-ed after the clear so a coincident event always survives W1C
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state           <= ST_IDLE;
      wb_ack_o        <= 1'b0;
      wb_err_o        <= 1'b0;
      wb_dat_o        <= '0;
      daq_control_reg <= '0;
      irq_en          <= '0;
      irq_st          <= '0;
      interrupt       <= 1'b0;
    end else begin
      irq_st    <= (irq_st & ~irq_clr) | daq_ch_event;
      interrupt <= |(irq_st & irq_en);
      case (state)
        ST_IDLE: begin
          if (access) begin
            wb_ack_o <= !unmapped;
            wb_err_o <= unmapped;
            wb_dat_o <= (!unmapped && !wb_we_i) ? rd_mux : '0;
            if (wr && is_global && off == G_CONTROL)
              daq_control_reg <= (daq_control_reg & ~mask) | (wb_dat_i & mask);
            if (wr && is_global && off == G_IRQ_ENABLE)
              irq_en <= (irq_en & ~mask[NUM_CH-1:0]) | (wb_dat_i[NUM_CH-1:0] & mask[NUM_CH-1:0]);
            state <= ST_RESP;
          end
        end
        default: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          wb_dat_o <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_daq_csr_bank.sv
// tb/tb_wb_daq_csr_bank.sv - randomized self-checking bench for wb_daq_csr_bank (NUM_CH=4)
module tb_wb_daq_csr_bank;

  localparam int NCH = 4;

  logic           wb_clk = 1'b0;
  logic           wb_rst = 1'b0;
  logic [7:0]     wb_adr_i = '0;
  logic [31:0]    wb_dat_i = '0;
  logic [3:0]     wb_sel_i = '0;
  logic           wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [2:0]     wb_cti_i = '0;
  logic [1:0]     wb_bte_i = '0;
  logic [31:0]    wb_dat_o;
  logic           wb_ack_o, wb_err_o, wb_rty_o, interrupt;
  logic [31:0]    daq_control_reg;
  logic [NCH*32-1:0] daq_ch_address, daq_ch_control;
  logic [NCH*32-1:0] daq_ch_status = '0;
  logic [NCH-1:0] daq_ch_event = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, in register-map terms
  logic [31:0] m_ctrl, m_st, m_en;
  logic [31:0] m_addr [NCH];
  logic [31:0] m_cctl [NCH];
  logic [31:0] st_in  [NCH];
  logic [31:0] rd;

  always #5 wb_clk = ~wb_clk;

  wb_daq_csr_bank #(.NUM_CH(NCH), .AW(8), .VERSION(16'h0002)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .daq_control_reg(daq_control_reg),
    .daq_ch_address(daq_ch_address), .daq_ch_control(daq_ch_control),
    .daq_ch_status(daq_ch_status), .daq_ch_event(daq_ch_event), .interrupt(interrupt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_st = '0; m_en = '0;
    for (int i = 0; i < NCH; i++) begin m_addr[i] = '0; m_cctl[i] = '0; end
  endtask

  task automatic check_outputs();
    chk("control_reg", daq_control_reg, m_ctrl);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("ch%0d_address", i), daq_ch_address[32*i +: 32], m_addr[i]);
      chk($sformatf("ch%0d_control", i), daq_ch_control[32*i +: 32], m_cctl[i]);
    end
    chk("interrupt", 32'(interrupt), 32'(|(m_st & m_en)));
  endtask

  task automatic bus(input logic [7:0] a, input logic we, input logic [31:0] d,
                     input logic [3:0] s, input logic [3:0] ev, output logic [31:0] rdata);
    logic [31:0] rv, m, clr;
    logic        xerr;
    int          ch, off;
    @(negedge wb_clk);
    for (int i = 0; i < NCH; i++) st_in[i] = $urandom;
    daq_ch_status = {st_in[3], st_in[2], st_in[1], st_in[0]};
    wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = s;
    wb_cti_i = 3'($urandom); wb_bte_i = 2'($urandom);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; daq_ch_event = ev;
    m = lanes(s); rv = '0; xerr = 1'b0; clr = '0; ch = 0; off = int'(a[3:2]);
    if (a < 8'h10) begin
      case (off)
        0: rv = m_ctrl;
        1: rv = m_st;
        2: rv = m_en;
        default: rv = {16'h0002, 8'h00, 8'(NCH)};
      endcase
    end else begin
      ch = int'(a[7:4]) - 1;
      if (ch >= NCH || off == 3) xerr = 1'b1;
      else if (off == 0) rv = m_addr[ch];
      else if (off == 1) rv = m_cctl[ch];
      else rv = st_in[ch];
    end
    @(posedge wb_clk); #1;
    rdata = wb_dat_o;
    chk("ack", 32'(wb_ack_o), 32'(!xerr));
    chk("err", 32'(wb_err_o), 32'(xerr));
    if (!we && !xerr) chk($sformatf("rdata@%02h", a), wb_dat_o, rv);
    if (we && !xerr) begin
      if (a < 8'h10) begin
        case (off)
          0: m_ctrl = (m_ctrl & ~m) | (d & m);
          1: clr = d & m & 32'hF;
          2: m_en = ((m_en & ~m) | (d & m)) & 32'hF;
          default: ;
        endcase
      end else if (off == 0) m_addr[ch] = (m_addr[ch] & ~m) | (d & m);
      else if (off == 1) m_cctl[ch] = (m_cctl[ch] & ~m) | (d & m);
    end
    m_st = (m_st & ~clr) | 32'(ev);
    @(negedge wb_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; daq_ch_event = '0;
    @(posedge wb_clk); #1;
    chk("single_term", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
    chk("dat_idle", wb_dat_o, 32'h0);
    check_outputs();
  endtask

  task automatic pulse(input logic [3:0] ev);
    @(negedge wb_clk); daq_ch_event = ev;
    @(negedge wb_clk); daq_ch_event = '0;
    m_st = m_st | 32'(ev);
    @(posedge wb_clk); #1;
    chk("irq_after_event", 32'(interrupt), 32'(|(m_st & m_en)));
  endtask

  always @(negedge wb_clk)
    if (wb_rst) chk("ack_err_exclusive", 32'(wb_ack_o & wb_err_o), 32'h0);

  initial begin
    logic [7:0] a;
    model_reset();
    repeat (3) @(posedge wb_clk);
    #1;
    chk("rst_ack", 32'(wb_ack_o), 0); chk("rst_err", 32'(wb_err_o), 0);
    chk("rst_rty", 32'(wb_rty_o), 0); chk("rst_dat", wb_dat_o, 0);
    check_outputs();
    @(negedge wb_clk) wb_rst = 1'b1;

    bus(8'h10, 1'b1, 32'h12345678, 4'hF, 4'h0, rd);
    chk("ch0_addr_out", daq_ch_address[31:0], 32'h12345678);
    bus(8'h10, 1'b0, 32'h0, 4'hF, 4'h0, rd);  chk("ch0_addr_rb", rd, 32'h12345678);
    bus(8'h0C, 1'b0, 32'h0, 4'hF, 4'h0, rd);  chk("config", rd, 32'h00020004);
    bus(8'h0C, 1'b1, 32'hFFFFFFFF, 4'hF, 4'h0, rd);
    bus(8'h34, 1'b1, 32'h0, 4'hF, 4'h0, rd);
    bus(8'h34, 1'b1, 32'hAABBCCDD, 4'b0101, 4'h0, rd);
    bus(8'h34, 1'b0, 32'h0, 4'hF, 4'h0, rd);  chk("byte_lanes", rd, 32'h00BB00DD);

    bus(8'h08, 1'b1, 32'h5, 4'hF, 4'h0, rd);
    pulse(4'h1); pulse(4'h2);
    bus(8'h04, 1'b0, 32'h0, 4'hF, 4'h0, rd);  chk("irq_status", rd, 32'h3);
    chk("irq_on", 32'(interrupt), 1);
    bus(8'h04, 1'b1, 32'h1, 4'h1, 4'h0, rd);  chk("irq_off", 32'(interrupt), 0);
    bus(8'h04, 1'b0, 32'h0, 4'hF, 4'h0, rd);  chk("irq_status_w1c", rd, 32'h2);
    bus(8'h04, 1'b1, 32'h2, 4'h0, 4'h0, rd);  // lane disabled: no clear
    bus(8'h04, 1'b0, 32'h0, 4'hF, 4'h0, rd);  chk("w1c_lane_off", rd, 32'h2);
    pulse(4'h4);
    bus(8'h04, 1'b1, 32'h4, 4'hF, 4'h4, rd);
    bus(8'h04, 1'b0, 32'h0, 4'hF, 4'h0, rd);  chk("set_wins", rd & 32'h4, 32'h4);

    bus(8'h1C, 1'b0, 32'h0, 4'hF, 4'h0, rd);
    bus(8'h1C, 1'b1, 32'hFFFFFFFF, 4'hF, 4'h0, rd);
    bus(8'h50, 1'b1, 32'hFFFFFFFF, 4'hF, 4'h0, rd);
    bus(8'h50, 1'b0, 32'h0, 4'hF, 4'h0, rd);
    bus(8'h4C, 1'b1, 32'hFFFFFFFF, 4'hF, 4'h0, rd);
    bus(8'hFC, 1'b0, 32'h0, 4'hF, 4'h0, rd);

    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 95));
      bus(a, 1'($urandom), $urandom, 4'($urandom),
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, rd);
    end

    bus(8'h00, 1'b1, 32'hCAFEF00D, 4'hF, 4'h0, rd);
    bus(8'h08, 1'b1, 32'hF, 4'hF, 4'h0, rd);
    pulse(4'hF);
    @(negedge wb_clk);
    wb_adr_i = 8'h00; wb_we_i = 1'b1; wb_dat_i = 32'h11111111; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    #2 wb_rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_ctrl", daq_control_reg, 32'h0);
    chk("async_rst_irq", 32'(interrupt), 0);
    @(posedge wb_clk); #1;
    chk("rst_mid_ack", 32'(wb_ack_o), 0);
    chk("rst_mid_dat", wb_dat_o, 0);
    check_outputs();
    @(negedge wb_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_rst = 1'b1;
    bus(8'h04, 1'b0, 32'h0, 4'hF, 4'h0, rd);  chk("post_rst_irq", rd, 32'h0);
    bus(8'h20, 1'b1, 32'h0BADBEEF, 4'hF, 4'h0, rd);
    bus(8'h20, 1'b0, 32'h0, 4'hF, 4'h0, rd);  chk("post_rst_rw", rd, 32'h0BADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
